// File: rtl/sequencia_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
package sequencia_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    CAPTURANDO = 2'd1,
    BUSCANDO   = 2'd2
  } estado_e;

endpackage

// File: rtl/sequencia_multi_if.sv
// Control, serial-data and status bundle between the detector and its neighbours.
interface sequencia_multi_if
  import sequencia_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             setar_palavra;
  logic [WIDTH-1:0] palavra;
  logic [WIDTH-1:0] mascara;
  logic             sobrepor;
  logic             start;
  logic             stop;
  logic             bit_valid;
  logic             bit_in;
  logic             encontrado;
  logic             encontrado_pulso;
  logic [CNT_W-1:0] contagem;
  logic             ocupado;

  modport master (
    output setar_palavra, palavra, mascara, sobrepor, start, stop, bit_valid, bit_in,
    input  encontrado, encontrado_pulso, contagem, ocupado
  );

  modport slave (
    input  setar_palavra, palavra, mascara, sobrepor, start, stop, bit_valid, bit_in,
    output encontrado, encontrado_pulso, contagem, ocupado
  );

endinterface

// File: rtl/sequencia_shift_cmp.sv
// Serial shift register, fill counter and masked comparator; raises a
// combinational match strobe on the valid bit that completes a matching window.
module sequencia_shift_cmp #(
  parameter int WIDTH  = 8,
  parameter int FILL_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             sobrepor,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] palavra,
  input  logic [WIDTH-1:0] mascara,
  output logic             match,
  output logic             completa
);

  logic [WIDTH-1:0]  sr_q, sr_d, sr_shift;
  logic [FILL_W-1:0] fill_q, fill_d;

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    sr_shift = {sr_q[WIDTH-2:0], bit_in};
    completa = shift_en && (fill_q >= FILL_W'(WIDTH - 1));
    match    = completa && (((sr_shift ^ palavra) & mascara) == '0);
    sr_d     = sr_q;
    fill_d   = fill_q;
    if (clear) begin
      sr_d   = '0;
      fill_d = '0;
    end else if (shift_en) begin
      sr_d = sr_shift;
      // Non-overlap: restart the fill so a full fresh window is required.
      if (match && !sobrepor) begin
        fill_d = '0;
      end else if (fill_q != FILL_W'(WIDTH)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      fill_q <= '0;
    end else begin
      sr_q   <= sr_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/sequencia_multi.sv
// Programmable MSB-first serial pattern detector with mask, overlap mode,
// one-cycle match pulse, sticky flag and saturating match counter.
module sequencia_multi
  import sequencia_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  sequencia_multi_if.slave bus
);

  estado_e          state_q, state_d;
  logic [WIDTH-1:0] palavra_q, palavra_d;
  logic [WIDTH-1:0] mascara_q, mascara_d;
  logic             sobrepor_q, sobrepor_d;
  logic             encontrado_q, encontrado_d;
  logic             pulso_q, pulso_d;
  logic [CNT_W-1:0] contagem_q, contagem_d;

  logic ocupado;
  logic shift_en;
  logic clear;
  logic match;
  logic completa;

  assign ocupado  = (state_q != OCIOSO);
  // Bits arriving together with start or stop are not consumed.
  assign shift_en = ocupado && bus.bit_valid && !bus.stop && !bus.start;
  assign clear    = bus.start && !bus.stop;

  sequencia_shift_cmp #(.WIDTH(WIDTH)) u_shift_cmp (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .shift_en (shift_en),
    .sobrepor (sobrepor_q),
    .bit_in   (bus.bit_in),
    .palavra  (palavra_q),
    .mascara  (mascara_q),
    .match    (match),
    .completa (completa)
  );

  always_comb begin
    state_d      = state_q;
    palavra_d    = palavra_q;
    mascara_d    = mascara_q;
    sobrepor_d   = sobrepor_q;
    encontrado_d = encontrado_q;
    contagem_d   = contagem_q;
    pulso_d      = 1'b0;

    if (bus.stop) begin
      state_d = OCIOSO;
    end else if (bus.start) begin
      state_d      = CAPTURANDO;
      sobrepor_d   = bus.sobrepor;
      encontrado_d = 1'b0;
      contagem_d   = '0;
      if (state_q == OCIOSO && bus.setar_palavra) begin
        palavra_d = bus.palavra;
        mascara_d = bus.mascara;
      end
    end else begin
      case (state_q)
        OCIOSO: begin
          if (bus.setar_palavra) begin
            palavra_d = bus.palavra;
            mascara_d = bus.mascara;
          end
        end
        CAPTURANDO, BUSCANDO: begin
          if (match) begin
            pulso_d      = 1'b1;
            encontrado_d = 1'b1;
            if (contagem_q != '1) contagem_d = contagem_q + CNT_W'(1);
          end
          if (match && !sobrepor_q) begin
            state_d = CAPTURANDO;
          end else if (completa) begin
            state_d = BUSCANDO;
          end
        end
        default: state_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= OCIOSO;
      palavra_q    <= '0;
      mascara_q    <= '0;
      sobrepor_q   <= 1'b0;
      encontrado_q <= 1'b0;
      pulso_q      <= 1'b0;
      contagem_q   <= '0;
    end else begin
      state_q      <= state_d;
      palavra_q    <= palavra_d;
      mascara_q    <= mascara_d;
      sobrepor_q   <= sobrepor_d;
      encontrado_q <= encontrado_d;
      pulso_q      <= pulso_d;
      contagem_q   <= contagem_d;
    end
  end

  assign bus.encontrado       = encontrado_q;
  assign bus.encontrado_pulso = pulso_q;
  assign bus.contagem         = contagem_q;
  assign bus.ocupado          = ocupado;

endmodule

// File: tb/tb_sequencia_multi.sv
// Directed bench: two detectors (8-bit and 2-bit counters) share one stimulus
// and are compared every cycle against a bit-history model, plus literal checks.
module tb_sequencia_multi;
  import sequencia_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         setar = 1'b0;
  logic [W-1:0] pal   = '0;
  logic [W-1:0] masc  = '0;
  logic         sobre = 1'b0;
  logic         start = 1'b0;
  logic         stop  = 1'b0;
  logic         valid = 1'b0;
  logic         bin   = 1'b0;

  sequencia_multi_if #(.WIDTH(W), .CNT_W(8)) if8 ();
  sequencia_multi_if #(.WIDTH(W), .CNT_W(2)) if2 ();

  assign if8.setar_palavra = setar;
  assign if8.palavra       = pal;
  assign if8.mascara       = masc;
  assign if8.sobrepor      = sobre;
  assign if8.start         = start;
  assign if8.stop          = stop;
  assign if8.bit_valid     = valid;
  assign if8.bit_in        = bin;
  assign if2.setar_palavra = setar;
  assign if2.palavra       = pal;
  assign if2.mascara       = masc;
  assign if2.sobrepor      = sobre;
  assign if2.start         = start;
  assign if2.stop          = stop;
  assign if2.bit_valid     = valid;
  assign if2.bit_in        = bin;

  sequencia_multi #(.WIDTH(W), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  sequencia_multi #(.WIDTH(W), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the valid bits seen since the search (re)started; a match is the
  // newest W bits agreeing with the pattern on every masked position.
  bit         m_active, m_found, m_pulse, m_ovl;
  bit [W-1:0] m_pat, m_mask;
  bit         hist[$];
  int         m_count;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    bit [W-1:0] word;
    m_pulse = 1'b0;
    if (rst) begin
      m_active = 0; m_found = 0; m_ovl = 0; m_pat = '0; m_mask = '0;
      m_count = 0; hist.delete();
    end else if (stop) begin
      m_active = 0;
    end else if (start) begin
      if (!m_active && setar) begin m_pat = pal; m_mask = masc; end
      m_active = 1; m_found = 0; m_count = 0; m_ovl = sobre; hist.delete();
    end else if (!m_active) begin
      if (setar) begin m_pat = pal; m_mask = masc; end
    end else if (valid) begin
      hist.push_back(bin);
      if (hist.size() > W) void'(hist.pop_front());
      if (hist.size() == W) begin
        for (int i = 0; i < W; i++) word[W-1-i] = hist[i];
        if (((word ^ m_pat) & m_mask) == '0) begin
          m_pulse = 1; m_found = 1; m_count++;
          if (!m_ovl) hist.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ocupado8",   32'(if8.ocupado),          32'(m_active));
      check("encontr8",   32'(if8.encontrado),       32'(m_found));
      check("pulso8",     32'(if8.encontrado_pulso), 32'(m_pulse));
      check("contagem8",  32'(if8.contagem),         (m_count > 255) ? 32'd255 : 32'(m_count));
      check("ocupado2",   32'(if2.ocupado),          32'(m_active));
      check("pulso2",     32'(if2.encontrado_pulso), 32'(m_pulse));
      check("contagem2",  32'(if2.contagem),         (m_count > 3) ? 32'd3 : 32'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit v, input bit b);
    valid = v; bin = b;
    tick();
    valid = 1'b0;
  endtask

  // Sends the low n bits of val, MSB first; with gaps an invalid junk bit precedes each.
  task automatic send(input logic [31:0] val, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) step(1'b0, ~val[i]);
      step(1'b1, val[i]);
    end
  endtask

  task automatic begin_search(input logic [W-1:0] p, input logic [W-1:0] m, input bit ovl);
    stop = 1'b1; tick(); stop = 1'b0;
    setar = 1'b1; pal = p; masc = m; tick(); setar = 1'b0;
    sobre = ovl; start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
    check("rst_ocupado", 32'(if8.ocupado), 0);
    check("rst_encontr", 32'(if8.encontrado), 0);
    check("rst_pulso", 32'(if8.encontrado_pulso), 0);
    check("rst_contagem", 32'(if8.contagem), 0);

    // Basic: 0x12A5 against 0xA5, single match on bit 16
    begin_search(8'hA5, 8'hFF, 1'b1);
    send(32'h12A5 >> 1, 15, 1'b0);
    check("basic_no_early_pulse", 32'(if8.encontrado_pulso), 0);
    step(1'b1, 1'b1);
    check("basic_pulse", 32'(if8.encontrado_pulso), 1);
    check("basic_encontr", 32'(if8.encontrado), 1);
    check("basic_cnt", 32'(if8.contagem), 1);
    check("basic_model_cnt", 32'(m_count), 1);
    step(1'b0, 1'b0);
    check("basic_pulse_drop", 32'(if8.encontrado_pulso), 0);

    // Overlap: 0xAAAA gives 5 matches
    begin_search(8'hAA, 8'hFF, 1'b1);
    send(32'hAAAA, 16, 1'b0);
    check("ovl_cnt", 32'(if8.contagem), 5);
    check("ovl_model_cnt", 32'(m_count), 5);

    // Restart while busy with non-overlap: 2 matches
    sobre = 1'b0; start = 1'b1; tick(); start = 1'b0;
    check("restart_cnt_clear", 32'(if8.contagem), 0);
    check("restart_enc_clear", 32'(if8.encontrado), 0);
    send(32'hAAAA, 16, 1'b0);
    check("novl_cnt", 32'(if8.contagem), 2);
    check("novl_model_cnt", 32'(m_count), 2);

    // Mask: high nibble only
    begin_search(8'hA0, 8'hF0, 1'b1);
    send(32'h00A7, 16, 1'b0);
    check("mask_cnt", 32'(if8.contagem), 1);

    // No match
    begin_search(8'hFF, 8'hFF, 1'b1);
    send(32'h7F7F, 16, 1'b0);
    check("nomatch_cnt", 32'(if8.contagem), 0);
    check("nomatch_enc", 32'(if8.encontrado), 0);

    // Valid gaps: match lands on the 8th valid bit
    begin_search(8'hA5, 8'hFF, 1'b1);
    send(32'hA5 >> 1, 7, 1'b1);
    check("gap_no_early_pulse", 32'(if8.encontrado_pulso), 0);
    step(1'b0, 1'b0);
    check("gap_invalid_no_pulse", 32'(if8.encontrado_pulso), 0);
    step(1'b1, 1'b1);
    check("gap_pulse", 32'(if8.encontrado_pulso), 1);

    // Saturation: zero mask, 12 bits -> 5 matches, 2-bit counter holds at 3
    begin_search(8'h00, 8'h00, 1'b1);
    send(32'hABC, 12, 1'b0);
    check("sat_cnt8", 32'(if8.contagem), 5);
    check("sat_cnt2", 32'(if2.contagem), 3);
    check("sat_model_cnt", 32'(m_count), 5);

    // setar_palavra while searching is ignored
    begin_search(8'hA5, 8'hFF, 1'b1);
    send(32'hFF, 8, 1'b0);
    setar = 1'b1; pal = 8'h00; tick(); setar = 1'b0;
    send(32'hA5, 8, 1'b0);
    check("setar_busy_cnt", 32'(if8.contagem), 1);

    // start and stop together: stop wins, status held
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("startstop_ocupado", 32'(if8.ocupado), 0);
    check("startstop_enc_held", 32'(if8.encontrado), 1);
    check("startstop_cnt_held", 32'(if8.contagem), 1);

    // setar_palavra with start in OCIOSO: new pattern used immediately
    setar = 1'b1; pal = 8'h3C; masc = 8'hFF; sobre = 1'b1; start = 1'b1; tick();
    setar = 1'b0; start = 1'b0;
    check("setstart_ocupado", 32'(if8.ocupado), 1);
    send(32'h3C, 8, 1'b0);
    check("setstart_cnt", 32'(if8.contagem), 1);

    // rst after 5 bits
    send(32'h15, 5, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_ocupado", 32'(if8.ocupado), 0);
    check("rst_mid_enc", 32'(if8.encontrado), 0);
    check("rst_mid_cnt", 32'(if8.contagem), 0);
    check("rst_mid_pulse", 32'(if8.encontrado_pulso), 0);
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
